// File: rtl/dma_xfer_pkg.sv
// Shared types and defaults for the DMA transfer responder.
package dma_xfer_pkg;

  localparam int DMA_XFER_LEN_DEF = 100;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } dma_xfer_state_t;

endpackage

// File: rtl/dma_req_edge.sv
// Rising-edge detector for the DMA request level. The history flop resets
// high so a request already asserted at reset release is not taken as a start.
module dma_req_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic dma_req,
  output logic rise
);

  logic req_q;

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) req_q <= 1'b1;
    else          req_q <= dma_req;
  end

  assign rise = dma_req & ~req_q;

endmodule

// File: rtl/dma_xfer_ctrl.sv
// DMA transfer responder: a request rise opens a burst of XFER_LEN beats on
// data_transfer, closed by a one-cycle done pulse (early on abort).
module dma_xfer_ctrl
  import dma_xfer_pkg::*;
#(
  parameter int XFER_LEN = DMA_XFER_LEN_DEF,
  parameter int CNT_W    = $clog2(XFER_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dma_req,
  input  logic             abort,
  output logic             data_transfer,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             aborted,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(XFER_LEN);
  localparam logic [CNT_W-1:0] FIRST_BEAT = CNT_W'(1);

  dma_xfer_state_t  state_q, state_d;
  logic             rise;
  logic             data_transfer_d, done_d, aborted_d, overrun_d;
  logic [CNT_W-1:0] beat_cnt_d;

  dma_req_edge u_req_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .dma_req (dma_req),
    .rise    (rise)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d         = state_q;
    data_transfer_d = data_transfer;
    done_d          = 1'b0;
    beat_cnt_d      = beat_cnt;
    aborted_d       = aborted;
    overrun_d       = overrun;

    unique case (state_q)
      IDLE, DONE: begin
        if (rise) begin
          state_d         = XFER;
          data_transfer_d = 1'b1;
          beat_cnt_d      = FIRST_BEAT;
          aborted_d       = 1'b0;
          overrun_d       = 1'b0;
        end else begin
          state_d         = IDLE;
          data_transfer_d = 1'b0;
        end
      end

      XFER: begin
        // A new rise mid-burst is only recorded; the burst runs on.
        if (rise) overrun_d = 1'b1;

        // The last beat wins over abort, so a late abort is a clean finish.
        if (beat_cnt == LAST_BEAT) begin
          state_d         = DONE;
          data_transfer_d = 1'b0;
          done_d          = 1'b1;
        end else if (abort) begin
          state_d         = DONE;
          data_transfer_d = 1'b0;
          done_d          = 1'b1;
          aborted_d       = 1'b1;
        end else begin
          beat_cnt_d      = beat_cnt + 1'b1;
        end
      end

      default: begin
        state_d         = IDLE;
        data_transfer_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      data_transfer <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      beat_cnt      <= '0;
      aborted       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_transfer <= data_transfer_d;
      done          <= done_d;
      busy          <= (state_d == XFER);
      beat_cnt      <= beat_cnt_d;
      aborted       <= aborted_d;
      overrun       <= overrun_d;
    end
  end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Bench for dma_xfer_ctrl: directed and random request/abort patterns compared
// cycle by cycle against a burst-level model of the handshake.
module tb_dma_xfer_ctrl;

  localparam int L    = 100;
  localparam int CW   = $clog2(L + 1);
  localparam int OW   = 5 + CW;
  localparam int MAXN = 512;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          dma_req = 1'b0;
  logic          abort = 1'b0;
  logic          data_transfer, done, busy, aborted, overrun;
  logic [CW-1:0] beat_cnt;

  int vectors = 0;
  int miscompares = 0;

  bit            req_v [MAXN];
  bit            abt_v [MAXN];
  logic [OW-1:0] exp_v [MAXN];

  dma_xfer_ctrl #(.XFER_LEN(L), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dma_req       (dma_req),
    .abort         (abort),
    .data_transfer (data_transfer),
    .done          (done),
    .busy          (busy),
    .beat_cnt      (beat_cnt),
    .aborted       (aborted),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {data_transfer, done, busy, aborted, overrun, beat_cnt}.
  function automatic logic [OW-1:0] obs();
    return {data_transfer, done, busy, aborted, overrun, beat_cnt};
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < MAXN; k++) begin
      req_v[k] = 1'b0;
      abt_v[k] = 1'b0;
    end
  endtask

  // Burst-level model. Cycle k is the edge that samples req_v[k]/abt_v[k];
  // exp_v[k] is what the outputs hold just after that edge. A burst accepted
  // at edge s ends at edge e (s+L, or the first abort edge inside it), with
  // data on s..e-1 and done at e. Rises at s+1..e are ignored (overrun).
  task automatic build_model(input int n);
    int s = -1;
    int e = -1;
    int cnt;
    bit ab = 1'b0;
    bit ovr = 1'b0;
    bit prev = 1'b1;
    bit rise, dt, dn, abd;
    for (int k = 0; k < n; k++) begin
      rise = req_v[k] && !prev;
      prev = req_v[k];
      if (rise && (s < 0 || k > e)) begin
        s   = k;
        e   = k + L;
        ab  = 1'b0;
        ovr = 1'b0;
        for (int a = k + 1; a < k + L; a++) begin
          if (a < n && abt_v[a] && e == k + L) begin
            e  = a;
            ab = 1'b1;
          end
        end
      end else if (rise) begin
        ovr = 1'b1;
      end
      dt  = (s >= 0) && (k < e);
      dn  = (s >= 0) && (k == e);
      cnt = (s < 0) ? 0 : ((k < e) ? (k - s + 1) : (e - s));
      abd = (s >= 0) && (k >= e) && ab;
      exp_v[k] = {dt, dn, dt, abd, ovr, CW'(cnt)};
    end
  endtask

  task automatic do_reset();
    dma_req = req_v[0];
    abort   = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive cycle k's inputs, then advance to the sampling point after its edge.
  task automatic step(input int k);
    dma_req = req_v[k];
    abort   = abt_v[k];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dma_req = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs() !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got %b, want %b", obs(), {OW{1'b0}});
    end
  endtask

  task automatic test_single_burst();
    clear_stim();
    for (int k = 3; k < MAXN; k++) req_v[k] = 1'b1;
    build_model(110);
    do_reset();
    for (int k = 0; k < 110; k++) begin
      step(k);
      vectors++;
      if (obs() !== exp_v[k]) begin
        miscompares++;
        $display("FAIL single_burst cycle %0d: got %b, want %b", k, obs(), exp_v[k]);
      end
    end
  endtask

  task automatic test_abort_mid();
    clear_stim();
    for (int k = 3; k < MAXN; k++) req_v[k] = 1'b1;
    abt_v[1]  = 1'b1;  // idle, ignored
    abt_v[40] = 1'b1;  // beat 37
    abt_v[41] = 1'b1;  // DONE cycle, ignored
    abt_v[45] = 1'b1;
    build_model(60);
    do_reset();
    for (int k = 0; k < 60; k++) begin
      step(k);
      vectors++;
      if (obs() !== exp_v[k]) begin
        miscompares++;
        $display("FAIL abort_beat37 cycle %0d: got %b, want %b", k, obs(), exp_v[k]);
      end
    end
  endtask

  task automatic test_abort_last();
    clear_stim();
    for (int k = 3; k < MAXN; k++) req_v[k] = 1'b1;
    abt_v[103] = 1'b1;  // beat 100
    abt_v[104] = 1'b1;
    build_model(110);
    do_reset();
    for (int k = 0; k < 110; k++) begin
      step(k);
      vectors++;
      if (obs() !== exp_v[k]) begin
        miscompares++;
        $display("FAIL abort_last_beat cycle %0d: got %b, want %b", k, obs(), exp_v[k]);
      end
    end
  endtask

  task automatic test_overrun();
    clear_stim();
    for (int k = 3; k < 110; k++) req_v[k] = 1'b1;
    req_v[51] = 1'b0;   // re-rise sampled on beat 50
    for (int k = 115; k < MAXN; k++) req_v[k] = 1'b1;
    build_model(130);
    do_reset();
    for (int k = 0; k < 130; k++) begin
      step(k);
      vectors++;
      if (obs() !== exp_v[k]) begin
        miscompares++;
        $display("FAIL overrun cycle %0d: got %b, want %b", k, obs(), exp_v[k]);
      end
    end
  endtask

  task automatic test_held_through_reset();
    clear_stim();
    for (int k = 0; k < 20; k++) req_v[k] = 1'b1;
    for (int k = 21; k < MAXN; k++) req_v[k] = 1'b1;
    build_model(130);
    do_reset();
    for (int k = 0; k < 130; k++) begin
      step(k);
      vectors++;
      if (obs() !== exp_v[k]) begin
        miscompares++;
        $display("FAIL held_through_reset cycle %0d: got %b, want %b", k, obs(), exp_v[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    for (int k = 3; k < 103; k++) req_v[k] = 1'b1;
    for (int k = 104; k < MAXN; k++) req_v[k] = 1'b1;  // rise in the DONE cycle
    build_model(210);
    do_reset();
    for (int k = 0; k < 210; k++) begin
      step(k);
      vectors++;
      if (obs() !== exp_v[k]) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got %b, want %b", k, obs(), exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_stim();
    for (int k = 3; k < MAXN; k++) req_v[k] = 1'b1;
    build_model(70);
    do_reset();
    for (int k = 0; k <= 62; k++) begin   // up to beat 60
      step(k);
      vectors++;
      if (obs() !== exp_v[k]) begin
        miscompares++;
        $display("FAIL pre_reset cycle %0d: got %b, want %b", k, obs(), exp_v[k]);
      end
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs() !== '0) begin
      miscompares++;
      $display("FAIL async_reset_drop: got %b, want %b", obs(), {OW{1'b0}});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (obs() !== '0) begin
        miscompares++;
        $display("FAIL held_in_reset cycle %0d: got %b, want %b", k, obs(), {OW{1'b0}});
      end
    end
    clear_stim();
    for (int k = 2; k < MAXN; k++) req_v[k] = 1'b1;
    build_model(110);
    do_reset();
    for (int k = 0; k < 110; k++) begin
      step(k);
      vectors++;
      if (obs() !== exp_v[k]) begin
        miscompares++;
        $display("FAIL post_reset_burst cycle %0d: got %b, want %b", k, obs(), exp_v[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      clear_stim();
      req_v[0] = 1'($urandom_range(0, 1));
      for (int k = 1; k < 400; k++) begin
        req_v[k] = ($urandom_range(0, 29) == 0) ? !req_v[k-1] : req_v[k-1];
        abt_v[k] = ($urandom_range(0, 79) == 0);
      end
      build_model(400);
      do_reset();
      for (int k = 0; k < 400; k++) begin
        step(k);
        vectors++;
        if (obs() !== exp_v[k]) begin
          miscompares++;
          $display("FAIL random iter %0d cycle %0d: got %b, want %b", it, k, obs(), exp_v[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_abort_mid();
    test_abort_last();
    test_overrun();
    test_held_through_reset();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_xfer_ctrl.md
# dma_xfer_ctrl

Responder side of the DMA request/transfer handshake. Detects a rising edge on `dma_req`, asserts `data_transfer` for exactly `XFER_LEN` consecutive cycles starting the cycle after the edge, then pulses `done`. An early `abort` ends the burst with a `done` pulse. It sits beside the DMA channel datapath and drives the `data_transfer`/`done` signals that the transfer assertions check.

## Interface
Parameters:
- `XFER_LEN`, default 100: beats per burst. Legal range is at least 2.
- `CNT_W`, default `$clog2(XFER_LEN+1)`: width of the beat counter.

Ports (single clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge active.
- `reset_n` in 1: asynchronous active-low reset.
- `dma_req` in 1: request level from the initiator. Only a 0→1 transition starts a burst.
- `abort` in 1: terminate an in-flight burst.
- `data_transfer` out 1: high on every beat of the burst.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high in XFER.
- `beat_cnt` out CNT_W: beats issued in the current or last burst (1..XFER_LEN).
- `aborted` out 1: sticky; the last burst ended by `abort`.
- `overrun` out 1: sticky; a `dma_req` rise was ignored during a burst.

## Operation
- Rise detect: `req_q` <= `dma_req`. `rise` = `dma_req & ~req_q`. `req_q` resets to 1, so a request held high through reset release is not a start; it must drop and rise again.
- FSM states: IDLE, XFER, DONE.
  - IDLE, `rise` → XFER. On the same edge: `beat_cnt`<=1, `data_transfer`<=1, clear `aborted` and `overrun`.
  - XFER, `beat_cnt`==XFER_LEN (last beat) → DONE, `data_transfer`<=0, `done`<=1.
  - XFER, `abort` and not the last beat → DONE, `data_transfer`<=0, `done`<=1, `aborted`<=1, `beat_cnt` frozen.
  - XFER otherwise → `beat_cnt`+1.
  - XFER, `rise` → ignored, `overrun`<=1. The burst continues unchanged.
  - DONE (always one cycle), `rise` → XFER with the same start actions as IDLE. Otherwise → IDLE, `done`<=0.
- `abort` in IDLE or DONE is ignored.
- `abort` on the last beat: normal completion, `aborted` stays 0.
- `beat_cnt` holds its final value in IDLE until the next start.
- All outputs are registered. No combinational path from input to output.

## Timing
- Reset values: `data_transfer`=0, `done`=0, `busy`=0, `beat_cnt`=0, `aborted`=0, `overrun`=0, state IDLE, `req_q`=1.
- Reset asserted mid-burst: all outputs drop asynchronously. No `done` is produced.
- Latency: `rise` is sampled at edge t. `data_transfer` is high at edges t+1 .. t+XFER_LEN, low at t+XFER_LEN+1. `done` is high only at edge t+XFER_LEN+1.
- Abort sampled at edge a inside a burst: `data_transfer` is low at a+1 and `done` is high at a+1.
- `done` and `data_transfer` are never high in the same cycle.
- Back-to-back: a `rise` sampled in the DONE cycle gives one cycle of `data_transfer` low between bursts.
- `beat_cnt` is never 0 while `busy` is high, and never exceeds XFER_LEN.

## Structure
- Package `dma_xfer_pkg`:
  - `typedef enum logic [1:0] {IDLE, XFER, DONE} dma_xfer_state_t`.
  - Default `XFER_LEN` constant `DMA_XFER_LEN_DEF = 100`.
- Sub-module `dma_req_edge`: registered rise detector with the reset-to-1 history flop, outputting `rise`.
- FSM, counter and sticky flags live in `dma_xfer_ctrl`.

## Test plan
- Single burst: release reset, raise `dma_req` → `data_transfer` high for exactly 100 cycles starting one cycle after the rise, `done`=1 on cycle 101, `beat_cnt`=100, `aborted`=0.
- Abort on beat 37 → `data_transfer` low the next cycle, `done` one cycle, `aborted`=1, `beat_cnt`=37. Abort on beat 100 → `aborted`=0.
- Lower and re-raise `dma_req` at beat 50 → burst still runs 100 beats, `overrun`=1 until the next accepted start.
- `dma_req` held high through reset release → no burst. Then drop it and raise it → burst starts normally.
- Rise sampled in the DONE cycle → second burst of 100 beats, exactly one idle cycle between bursts.
- Assert `reset_n`=0 at beat 60 → all outputs 0 immediately, no `done`. After release with `dma_req` low-then-high → a full 100-beat burst.
